port_alloc_deflect: RTL

Output-port allocator for the bufferless deflection router. Each cycle it takes the productive-port vectors from the four network input ports' route-computation units plus one local injection request. It assigns every valid network flit exactly one distinct output port, preferring productive ports and deflecting the losers, and admits the injection flit only into a leftover port. Sits between the per-port route computation and the output crossbar; grants are registered and drive crossbar selects directly.

---
 rtl/port_alloc_deflect_pkg.sv | 25 ++
 rtl/port_alloc_deflect_port_pick.sv | 38 +++
 rtl/port_alloc_deflect.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/port_alloc_deflect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : port_alloc_deflect_pkg
// Description : Shared router constants for the deflection port allocator:
//               port count and the fixed output-port index assignment
//               (W=0, E=1, S=2, N=3, Local=4).
// Revision    : 1.0  initial release
// ============================================================================
package port_alloc_deflect_pkg;

    localparam int c_NUM_PORT = 5;
    localparam int c_NUM_NET  = 4;

    localparam int c_PORT_W = 0;
    localparam int c_PORT_E = 1;
    localparam int c_PORT_S = 2;
    localparam int c_PORT_N = 3;
    localparam int c_PORT_L = 4;

    // Network ports only (Local excluded); deflection and injection never
    // target Local.
    localparam logic [c_NUM_PORT-1:0] c_NET_MASK = 5'b01111;

endpackage : port_alloc_deflect_pkg
`default_nettype wire

// File: rtl/port_alloc_deflect_port_pick.sv
`default_nettype none
// ============================================================================
// Module      : port_pick
// Description : Combinational single-port chooser. Takes the lowest free
//               candidate port; if no candidate is free it falls back to the
//               lowest free network port (Local never used as a fallback).
// Ports       : i_cand    candidate (productive) port vector
//               i_free    ports still unallocated this cycle
//               i_netOnly restrict candidates to network ports
//               o_pick    one-hot chosen port (zero if nothing usable)
//               o_found   a candidate port was taken (not a fallback)
// Revision    : 1.0  initial release
// ============================================================================
module port_pick
    import port_alloc_deflect_pkg::*;
(
    input  logic [c_NUM_PORT-1:0] i_cand,
    input  logic [c_NUM_PORT-1:0] i_free,
    input  logic                  i_netOnly,
    output logic [c_NUM_PORT-1:0] o_pick,
    output logic                  o_found
);

    logic [c_NUM_PORT-1:0] w_eligible;
    logic [c_NUM_PORT-1:0] w_hit;
    logic [c_NUM_PORT-1:0] w_src;

    always_comb begin
        w_eligible = i_free & (i_netOnly ? c_NET_MASK : {c_NUM_PORT{1'b1}});
        w_hit      = i_cand & w_eligible;
        o_found    = |w_hit;
        w_src      = o_found ? w_hit : (i_free & c_NET_MASK);
        // Isolate the lowest set bit (two's-complement trick).
        o_pick     = w_src & (~w_src + 1'b1);
    end

endmodule : port_pick
`default_nettype wire

// File: rtl/port_alloc_deflect.sv
`default_nettype none
// ============================================================================
// Module      : port_alloc_deflect
// Description : Output-port allocator for a bufferless deflection router.
//               Network inputs are served in rotating priority order; each
//               valid flit gets its lowest free productive port or else the
//               lowest free network port (deflection). The local injection
//               flit only gets a network port left over after that.
//               All results are registered (latency 1).
// Ports       : clk, reset    clock, synchronous active-high reset
//               valid_in[4]   flit present per network input (W,E,S,N)
//               prod_in[20]   productive vector per input, input i at [5i+4:5i]
//               inj_req       local injection flit waiting
//               inj_prod[5]   productive vector of the injection flit
//               grant_out[20] one-hot granted port per input (0 if invalid)
//               deflected[4]  input got a non-productive port
//               inj_grant     injection accepted
//               inj_port[5]   one-hot injection port (0 if not granted)
//               prio_ptr[2]   current highest-priority input
//               deflect_cnt   saturating deflection count
// Revision    : 1.0  initial release
// ============================================================================
module port_alloc_deflect
    import port_alloc_deflect_pkg::*;
#(
    parameter int WIDTH_CNT = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [c_NUM_NET-1:0]            valid_in,
    input  logic [c_NUM_NET*c_NUM_PORT-1:0] prod_in,
    input  logic                            inj_req,
    input  logic [c_NUM_PORT-1:0]           inj_prod,
    output logic [c_NUM_NET*c_NUM_PORT-1:0] grant_out,
    output logic [c_NUM_NET-1:0]            deflected,
    output logic                            inj_grant,
    output logic [c_NUM_PORT-1:0]           inj_port,
    output logic [1:0]                      prio_ptr,
    output logic [WIDTH_CNT-1:0]            deflect_cnt
);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [c_NUM_NET*c_NUM_PORT-1:0] r_grantOut;
    logic [c_NUM_NET-1:0]            r_deflected;
    logic                            r_injGrant;
    logic [c_NUM_PORT-1:0]           r_injPort;
    logic [1:0]                      r_prioPtr;
    logic [WIDTH_CNT-1:0]            r_deflectCnt;

    // ------------------------------------------------------------------
    // Allocation chain, indexed by priority slot (slot 0 = prio_ptr)
    // ------------------------------------------------------------------
    logic [c_NUM_PORT-1:0]           w_prod     [0:c_NUM_NET-1];
    logic [c_NUM_PORT-1:0]           w_free     [0:c_NUM_NET];
    logic [1:0]                      w_slotIdx  [0:c_NUM_NET-1];
    logic [c_NUM_PORT-1:0]           w_slotCand [0:c_NUM_NET-1];
    logic [c_NUM_PORT-1:0]           w_slotPick [0:c_NUM_NET-1];
    logic [c_NUM_NET-1:0]            w_slotValid;
    logic [c_NUM_NET-1:0]            w_slotFound;

    // Per-input results mapped back from slot order
    logic [1:0]                      w_slotOf   [0:c_NUM_NET-1];
    logic [c_NUM_NET*c_NUM_PORT-1:0] w_grantFlat;
    logic [c_NUM_NET-1:0]            w_deflected;

    // Injection
    logic [c_NUM_PORT-1:0]           w_injPick;
    logic                            w_injFound;
    logic                            w_injOk;
    logic [c_NUM_PORT-1:0]           w_injPort;

    // Counter
    logic [2:0]                      w_deflPop;
    logic [WIDTH_CNT:0]              w_cntSum;
    logic [WIDTH_CNT-1:0]            w_cntNext;

    // All five outputs free at the start; Local has capacity 1, so it
    // simply drops out of the free set once taken.
    assign w_free[0] = {c_NUM_PORT{1'b1}};

    generate
        for (genvar i = 0; i < c_NUM_NET; i++) begin : g_unpack
            assign w_prod[i] = prod_in[i*c_NUM_PORT +: c_NUM_PORT];
        end

        for (genvar k = 0; k < c_NUM_NET; k++) begin : g_slot
            assign w_slotIdx[k]   = r_prioPtr + 2'(k);
            assign w_slotValid[k] = valid_in[w_slotIdx[k]];
            assign w_slotCand[k]  = w_prod[w_slotIdx[k]];

            port_pick u_pick (
                .i_cand    (w_slotCand[k]),
                .i_free    (w_free[k]),
                .i_netOnly (1'b0),
                .o_pick    (w_slotPick[k]),
                .o_found   (w_slotFound[k])
            );

            // An idle slot consumes nothing; its pick is discarded.
            assign w_free[k+1] = w_slotValid[k] ? (w_free[k] & ~w_slotPick[k])
                                                : w_free[k];
        end

        for (genvar i = 0; i < c_NUM_NET; i++) begin : g_input
            // Slot that served input i in this cycle's rotation.
            assign w_slotOf[i] = 2'(i) - r_prioPtr;
            assign w_grantFlat[i*c_NUM_PORT +: c_NUM_PORT] =
                valid_in[i] ? w_slotPick[w_slotOf[i]] : {c_NUM_PORT{1'b0}};
            assign w_deflected[i] = valid_in[i] & ~w_slotFound[w_slotOf[i]];
        end
    endgenerate

    // Injection sees only what the network flits left over; netOnly keeps
    // it off Local even when inj_prod requests Local.
    port_pick u_injPick (
        .i_cand    (inj_prod),
        .i_free    (w_free[c_NUM_NET]),
        .i_netOnly (1'b1),
        .o_pick    (w_injPick),
        .o_found   (w_injFound)
    );

    assign w_injOk   = inj_req & (w_injFound | (|(w_free[c_NUM_NET] & c_NET_MASK)));
    assign w_injPort = w_injOk ? w_injPick : {c_NUM_PORT{1'b0}};

    assign w_deflPop = {2'b00, w_deflected[0]} + {2'b00, w_deflected[1]}
                     + {2'b00, w_deflected[2]} + {2'b00, w_deflected[3]};
    assign w_cntSum  = {1'b0, r_deflectCnt} + (WIDTH_CNT+1)'(w_deflPop);
    assign w_cntNext = w_cntSum[WIDTH_CNT] ? {WIDTH_CNT{1'b1}}
                                           : w_cntSum[WIDTH_CNT-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grantOut   <= '0;
            r_deflected  <= '0;
            r_injGrant   <= 1'b0;
            r_injPort    <= '0;
            r_prioPtr    <= 2'd0;
            r_deflectCnt <= '0;
        end else begin
            r_grantOut   <= w_grantFlat;
            r_deflected  <= w_deflected;
            r_injGrant   <= w_injOk;
            r_injPort    <= w_injPort;
            r_deflectCnt <= w_cntNext;
            if (|valid_in) begin
                r_prioPtr <= r_prioPtr + 2'd1;
            end
        end
    end

    assign grant_out   = r_grantOut;
    assign deflected   = r_deflected;
    assign inj_grant   = r_injGrant;
    assign inj_port    = r_injPort;
    assign prio_ptr    = r_prioPtr;
    assign deflect_cnt = r_deflectCnt;

endmodule : port_alloc_deflect
`default_nettype wire
